// File: rtl/inst_sequencer.sv
// inst_sequencer: program sequencer for the accelerator.
// Fetches 32-bit instructions, runs NOP/REPEAT/JUMP internally and issues
// MATMUL/ACCMOV/FLUSHBUFFER commands over a valid/ready channel.
// Optional build macro SEQ_STRIDE_EN: repeated MATMUL/ACCMOV commands advance
// their x/w addresses by STRIDE on every repeated handshake.
module inst_sequencer #(
    parameter int IADDR_W = 14,
    parameter int REP_W   = 12,
    parameter int STRIDE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IADDR_W-1:0] start_addr,
    input  logic               abort,
    output logic               imem_en,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [3:0]         cmd_op,
    output logic [11:0]        cmd_x_addr,
    output logic [11:0]        cmd_w_addr,
    output logic [27:0]        cmd_len,
    output logic [4:0]         cmd_act_mask,
    output logic               busy,
    output logic               halted,
    output logic               error,
    output logic [IADDR_W-1:0] pc
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_MATMUL = 4'd1;
    localparam logic [3:0] OP_REPEAT = 4'd2;
    localparam logic [3:0] OP_ACCMOV = 4'd3;
    localparam logic [3:0] OP_FLUSH  = 4'd4;
    localparam logic [3:0] OP_JUMP   = 4'd14;

`ifdef SEQ_STRIDE_EN
    // Address advance applied on each repeated handshake.
    localparam logic [11:0] STRIDE_STEP = 12'(STRIDE);
`else
    // Striding disabled: repeated commands carry identical fields.
    localparam logic [11:0] STRIDE_STEP = 12'(STRIDE) & 12'h000;
`endif

    logic [2:0]         state_q, state_d;
    logic [IADDR_W-1:0] pc_q, pc_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               rep_armed_q, rep_armed_d;
    logic [3:0]         op_q, op_d;
    logic [11:0]        x_q, x_d;
    logic [11:0]        w_q, w_d;
    logic [27:0]        len_q, len_d;
    logic [4:0]         mask_q, mask_d;

    logic [3:0]         ins_op;
    logic [IADDR_W-1:0] jump_tgt;
    logic [REP_W-1:0]   rep_len;
    logic [IADDR_W-1:0] pc_inc;

    assign ins_op   = imem_rdata[31:28];
    assign jump_tgt = imem_rdata[14 +: IADDR_W];
    assign rep_len  = imem_rdata[16 +: REP_W];
    assign pc_inc   = pc_q + IADDR_W'(1);

    // Next-state, program-counter, repeat and command-field logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        op_d        = op_q;
        x_d         = x_q;
        w_d         = w_q;
        len_d       = len_q;
        mask_d      = mask_q;

        if (abort) begin
            // Abort wins over everything, including a same-cycle handshake.
            state_d     = S_IDLE;
            rep_armed_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        state_d     = S_FETCH;
                        pc_d        = start_addr;
                        rep_armed_d = 1'b0;
                    end
                end
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    case (ins_op)
                        OP_NOP: begin
                            pc_d    = pc_inc;
                            state_d = S_FETCH;
                        end
                        OP_REPEAT: begin
                            if (rep_armed_q) begin
                                state_d = S_ERROR;
                            end else begin
                                rep_cnt_d   = rep_len;
                                rep_armed_d = 1'b1;
                                pc_d        = pc_inc;
                                state_d     = S_FETCH;
                            end
                        end
                        OP_JUMP: begin
                            if (rep_armed_q) begin
                                state_d = S_ERROR;
                            end else if (jump_tgt == pc_q) begin
                                state_d = S_HALT;
                            end else begin
                                pc_d    = jump_tgt;
                                state_d = S_FETCH;
                            end
                        end
                        OP_MATMUL, OP_ACCMOV, OP_FLUSH: begin
                            if (rep_armed_q && (rep_cnt_q == '0)) begin
                                // REPEAT 0 swallows this instruction.
                                rep_armed_d = 1'b0;
                                pc_d        = pc_inc;
                                state_d     = S_FETCH;
                            end else begin
                                state_d = S_ISSUE;
                                op_d    = ins_op;
                                x_d     = (ins_op == OP_FLUSH) ? 12'd0 : imem_rdata[27:16];
                                w_d     = (ins_op == OP_MATMUL) ? imem_rdata[15:4] : 12'd0;
                                mask_d  = (ins_op == OP_ACCMOV) ? imem_rdata[10:6] : 5'd0;
                                case (ins_op)
                                    OP_ACCMOV: len_d = {23'd0, imem_rdata[15:11]};
                                    OP_FLUSH:  len_d = imem_rdata[27:0];
                                    default:   len_d = 28'd0;
                                endcase
                            end
                        end
                        default: state_d = S_ERROR;
                    endcase
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        if (rep_armed_q && (rep_cnt_q > REP_W'(1))) begin
                            rep_cnt_d = rep_cnt_q - REP_W'(1);
                            x_d = x_q + ((op_q == OP_FLUSH) ? 12'd0 : STRIDE_STEP);
                            w_d = w_q + ((op_q == OP_MATMUL) ? STRIDE_STEP : 12'd0);
                        end else begin
                            rep_armed_d = 1'b0;
                            pc_d        = pc_inc;
                            state_d     = S_FETCH;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            op_q        <= 4'd0;
            x_q         <= 12'd0;
            w_q         <= 12'd0;
            len_q       <= 28'd0;
            mask_q      <= 5'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            op_q        <= op_d;
            x_q         <= x_d;
            w_q         <= w_d;
            len_q       <= len_d;
            mask_q      <= mask_d;
        end
    end

    assign imem_en      = (state_q == S_FETCH);
    assign imem_addr    = pc_q;
    assign cmd_valid    = (state_q == S_ISSUE);
    assign cmd_op       = op_q;
    assign cmd_x_addr   = x_q;
    assign cmd_w_addr   = w_q;
    assign cmd_len      = len_q;
    assign cmd_act_mask = mask_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE);
    assign halted       = (state_q == S_HALT);
    assign error        = (state_q == S_ERROR);
    assign pc           = pc_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Testbench for inst_sequencer: instruction-level reference interpreter,
// randomized programs and ready patterns, directed edge cases.
module tb_inst_sequencer;

    localparam int AW     = 4;
    localparam int RW     = 12;
    localparam int STRIDE = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cmd_ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = 32'd0;
    logic          cmd_valid;
    logic [3:0]    cmd_op;
    logic [11:0]   cmd_x_addr, cmd_w_addr;
    logic [27:0]   cmd_len;
    logic [4:0]    cmd_act_mask;
    logic          busy, halted, error;
    logic [AW-1:0] pc;

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
    int cyc = 0;
    int stab_err = 0;

    logic [31:0]   mem [16];
    logic [60:0]   got[$], exp_q[$];
    logic [AW-1:0] ftr[$], exp_tr[$];
    logic [60:0]   cur;

    assign cur = {cmd_op, cmd_x_addr, cmd_w_addr, cmd_len, cmd_act_mask};

    inst_sequencer #(.IADDR_W(AW), .REP_W(RW), .STRIDE(STRIDE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .abort(abort), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x_addr(cmd_x_addr), .cmd_w_addr(cmd_w_addr),
        .cmd_len(cmd_len), .cmd_act_mask(cmd_act_mask), .busy(busy),
        .halted(halted), .error(error), .pc(pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    // Ready pattern generator.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: cmd_ready = 1'b1;
            1: cmd_ready = ~cmd_ready;
            2: cmd_ready = ($urandom_range(0, 1) == 1);
            default: cmd_ready = 1'b0;
        endcase
    end

    // Observer: handshakes, fetch trace, valid/field stability.
    logic pv = 1'b0, pr = 1'b0, pa = 1'b0;
    logic [60:0] pf = '0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr && !pa && (!cmd_valid || cur != pf)) stab_err++;
            if (cmd_valid && cmd_ready) got.push_back(cur);
            if (imem_en) ftr.push_back(imem_addr);
            pv = cmd_valid; pr = cmd_ready; pa = abort; pf = cur;
        end
    end

    function automatic logic [31:0] i_mm(input logic [11:0] x, input logic [11:0] w);
        return {4'd1, x, w, 4'd0};
    endfunction
    function automatic logic [31:0] i_rep(input logic [11:0] l);
        return {4'd2, l, 16'd0};
    endfunction
    function automatic logic [31:0] i_acc(input logic [11:0] y, input logic [4:0] l, input logic [4:0] m);
        return {4'd3, y, l, m, 6'd0};
    endfunction
    function automatic logic [31:0] i_fl(input logic [27:0] l);
        return {4'd4, l};
    endfunction
    function automatic logic [31:0] i_jmp(input logic [13:0] t);
        return {4'hE, t, 14'd0};
    endfunction

    // Command expected for iteration i of an issuable instruction word.
    function automatic logic [60:0] mk(input logic [31:0] w, input int i);
        logic [11:0] x, wa;
        logic [27:0] l;
        logic [4:0]  m;
        int step;
`ifdef SEQ_STRIDE_EN
        step = STRIDE;
`else
        step = 0;
`endif
        x = 12'd0; wa = 12'd0; l = 28'd0; m = 5'd0;
        case (w[31:28])
            4'd1: begin x = w[27:16]; wa = w[15:4]; end
            4'd3: begin x = w[27:16]; l = {23'd0, w[15:11]}; m = w[10:6]; end
            default: l = w[27:0];
        endcase
        if (w[31:28] != 4'd4) x = x + 12'(i * step);
        if (w[31:28] == 4'd1) wa = wa + 12'(i * step);
        return {w[31:28], x, wa, l, m};
    endfunction

    // Reference interpreter: walks the program one instruction at a time.
    task automatic model(input logic [AW-1:0] sa, output bit e_halt, output bit e_err,
                         output logic [AW-1:0] e_pc);
        logic [AW-1:0] p;
        logic [31:0]   w;
        bit            armed;
        int            cnt, n;
        exp_q.delete(); exp_tr.delete();
        p = sa; armed = 0; cnt = 0; e_halt = 0; e_err = 0;
        for (int k = 0; k < 200; k++) begin
            w = mem[p];
            exp_tr.push_back(p);
            if (w[31:28] == 4'd0) begin
                p = p + AW'(1);
            end else if (w[31:28] == 4'd2) begin
                if (armed) begin e_err = 1; break; end
                cnt = int'(w[27:16]); armed = 1; p = p + AW'(1);
            end else if (w[31:28] == 4'hE) begin
                if (armed) begin e_err = 1; break; end
                if (w[14 +: AW] == p) begin e_halt = 1; break; end
                p = w[14 +: AW];
            end else if (w[31:28] == 4'd1 || w[31:28] == 4'd3 || w[31:28] == 4'd4) begin
                n = armed ? cnt : 1;
                armed = 0;
                for (int i = 0; i < n; i++) exp_q.push_back(mk(w, i));
                p = p + AW'(1);
            end else begin
                e_err = 1; break;
            end
        end
        e_pc = p;
    endtask

    function automatic int q_diff();
        if (got.size() != exp_q.size()) return -2;
        foreach (got[i]) if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction
    function automatic int tr_diff();
        if (ftr.size() != exp_tr.size()) return -2;
        foreach (ftr[i]) if (ftr[i] !== exp_tr[i]) return i;
        return -1;
    endfunction

    // Start a program and wait (bounded) for HALT or ERROR.
    task automatic run_prog(input logic [AW-1:0] sa, input int budget, output bit done, output int lat);
        int f0, v0;
        got.delete(); ftr.delete();
        f0 = -1; v0 = -1; done = 0;
        @(posedge clk); #1 start = 1'b1; start_addr = sa;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (f0 < 0 && imem_en) f0 = cyc;
            if (v0 < 0 && cmd_valid) v0 = cyc;
            if (halted || error) begin done = 1; break; end
        end
        lat = (v0 >= 0 && f0 >= 0) ? v0 - f0 : -1;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid) begin seen = 1; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({cmd_valid, busy, halted, error, imem_en} !== 5'd0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000", {cmd_valid, busy, halted, error, imem_en});
        end
        checks++;
        if (pc !== '0 || cur !== '0 || imem_addr !== '0) begin
            failures++;
            $display("FAIL reset_values: pc=%0d fields=%h addr=%0d want all 0", pc, cur, imem_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic;
        bit done, eh, ee; int lat; logic [AW-1:0] ep;
        mem[0] = i_mm(12'd5, 12'd9); mem[1] = i_jmp(14'd1);
        ready_mode = 0;
        model(4'd0, eh, ee, ep);
        run_prog(4'd0, 100, done, lat);
        checks++;
        if (!done || !halted || pc !== 4'd1 || pc !== ep) begin
            failures++;
            $display("FAIL basic_halt: done=%0d halted=%0d pc=%0d want halted pc=1", done, halted, pc);
        end
        checks++;
        if (q_diff() !== -1 || got.size() !== 1) begin
            failures++;
            $display("FAIL basic_cmd: got %0d cmds diff=%0d want 1 op=1 x=5 w=9", got.size(), q_diff());
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles want 2", lat);
        end
        $display("test_basic cmds=%0d latency=%0d", got.size(), lat);
    endtask

    task automatic test_repeat_accmov;
        bit done, eh, ee; int lat, s0; logic [AW-1:0] ep;
        mem[0] = i_rep(12'd3); mem[1] = i_acc(12'h010, 5'd8, 5'h1F); mem[2] = i_jmp(14'd2);
        ready_mode = 1;
        s0 = stab_err;
        model(4'd0, eh, ee, ep);
        run_prog(4'd0, 200, done, lat);
        checks++;
        if (!done || got.size() !== 3 || q_diff() !== -1) begin
            failures++;
            $display("FAIL repeat3_cmds: got %0d cmds diff=%0d want 3", got.size(), q_diff());
        end
        checks++;
        if (stab_err !== s0) begin
            failures++;
            $display("FAIL repeat3_stable: got %0d violations want 0", stab_err - s0);
        end
        // REPEAT, NOP, MATMUL: NOP keeps the repeat armed.
        mem[8] = i_rep(12'd2); mem[9] = 32'd0; mem[10] = i_mm(12'h123, 12'h456); mem[11] = i_jmp(14'd11);
        ready_mode = 0;
        model(4'd8, eh, ee, ep);
        run_prog(4'd8, 200, done, lat);
        checks++;
        if (!done || got.size() !== 2 || q_diff() !== -1) begin
            failures++;
            $display("FAIL repeat_nop: got %0d cmds diff=%0d want 2", got.size(), q_diff());
        end
        $display("test_repeat_accmov cmds=%0d", got.size());
    endtask

    task automatic test_repeat_zero;
        bit done, eh, ee; int lat; logic [AW-1:0] ep;
        mem[0] = i_rep(12'd0); mem[1] = i_mm(12'd1, 12'd2); mem[2] = i_fl(28'h0ABCDEF); mem[3] = i_jmp(14'd3);
        ready_mode = 2;
        model(4'd0, eh, ee, ep);
        run_prog(4'd0, 200, done, lat);
        checks++;
        if (!done || got.size() !== 1 || q_diff() !== -1) begin
            failures++;
            $display("FAIL repeat0: got %0d cmds diff=%0d want 1 flush len=0abcdef", got.size(), q_diff());
        end
        $display("test_repeat_zero cmds=%0d", got.size());
    endtask

    task automatic test_error;
        bit done, eh, ee; int lat; logic [AW-1:0] ep;
        mem[0] = 32'd0; mem[1] = 32'd0; mem[2] = 32'h7000_0000;
        ready_mode = 0;
        run_prog(4'd0, 100, done, lat);
        checks++;
        if (!done || error !== 1'b1 || busy !== 1'b0 || got.size() !== 0) begin
            failures++;
            $display("FAIL bad_opcode: error=%0d busy=%0d cmds=%0d want 1 0 0", error, busy, got.size());
        end
        mem[2] = i_mm(12'd7, 12'd8); mem[3] = i_jmp(14'd3);
        model(4'd1, eh, ee, ep);
        run_prog(4'd1, 100, done, lat);
        checks++;
        if (!done || !halted || tr_diff() !== -1 || q_diff() !== -1) begin
            failures++;
            $display("FAIL restart_from_error: halted=%0d trace_diff=%0d cmd_diff=%0d want halted, match",
                     halted, tr_diff(), q_diff());
        end
        // REPEAT, NOP, REPEAT -> error.
        mem[4] = i_rep(12'd2); mem[5] = 32'd0; mem[6] = i_rep(12'd1);
        run_prog(4'd4, 100, done, lat);
        checks++;
        if (!done || error !== 1'b1 || got.size() !== 0) begin
            failures++;
            $display("FAIL repeat_repeat: error=%0d cmds=%0d want error, 0 cmds", error, got.size());
        end
        $display("test_error done");
    endtask

    task automatic test_wrap;
        bit done, eh, ee; int lat; logic [AW-1:0] ep;
        mem[15] = 32'd0; mem[0] = i_jmp(14'h3FF1); mem[1] = i_jmp(14'h0001);
        ready_mode = 0;
        model(4'd15, eh, ee, ep);
        run_prog(4'd15, 100, done, lat);
        checks++;
        if (!done || !halted || pc !== 4'd1 || tr_diff() !== -1) begin
            failures++;
            $display("FAIL pc_wrap: halted=%0d pc=%0d trace_diff=%0d want halted pc=1 trace 15,0,1",
                     halted, pc, tr_diff());
        end
        $display("test_wrap fetches=%0d", ftr.size());
    endtask

    task automatic test_abort;
        bit done, seen, eh, ee; int lat; logic [AW-1:0] ep;
        mem[0] = i_mm(12'h021, 12'h022); mem[1] = i_jmp(14'd1);
        ready_mode = 3;
        @(posedge clk); #1 start = 1'b1; start_addr = 4'd0;
        @(posedge clk); #1 start = 1'b0;
        wait_valid(seen);
        // start while busy must be ignored
        @(posedge clk); #1 start = 1'b1; start_addr = 4'd9;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (!seen || cmd_valid !== 1'b1 || pc !== 4'd0) begin
            failures++;
            $display("FAIL start_busy: seen=%0d valid=%0d pc=%0d want 1 1 0", seen, cmd_valid, pc);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL abort_drop: valid=%0d busy=%0d halted=%0d error=%0d want all 0",
                     cmd_valid, busy, halted, error);
        end
        abort = 1'b0;
        // Abort while a repeat is armed must disarm it.
        mem[4] = i_rep(12'd3); mem[5] = i_mm(12'h0A0, 12'h0B0); mem[6] = i_jmp(14'd6);
        @(posedge clk); #1 start = 1'b1; start_addr = 4'd4;
        @(posedge clk); #1 start = 1'b0;
        wait_valid(seen);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        ready_mode = 0;
        model(4'd5, eh, ee, ep);
        run_prog(4'd5, 100, done, lat);
        checks++;
        if (!seen || !done || got.size() !== 1 || q_diff() !== -1) begin
            failures++;
            $display("FAIL abort_disarm: seen=%0d cmds=%0d diff=%0d want 1 cmd", seen, got.size(), q_diff());
        end
        $display("test_abort cmds=%0d", got.size());
    endtask

    task automatic test_random;
        bit done, eh, ee; int lat, r, t, s0; logic [AW-1:0] ep, sa;
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < 15; k++) begin
                r = $urandom_range(0, 99);
                if (r < 15)      mem[k] = {4'd0, 28'($urandom)};
                else if (r < 35) mem[k] = {4'd1, 28'($urandom)};
                else if (r < 50) mem[k] = {4'd3, 28'($urandom)};
                else if (r < 62) mem[k] = {4'd4, 28'($urandom)};
                else if (r < 80) mem[k] = {4'd2, 12'($urandom_range(0, 3)), 16'($urandom)};
                else if (r < 95) begin
                    t = $urandom_range(k + 1, 15);
                    mem[k] = {4'hE, 10'($urandom), 4'(t), 14'($urandom)};
                end else mem[k] = {4'($urandom_range(5, 13)), 28'($urandom)};
            end
            mem[15] = {4'hE, 10'($urandom), 4'd15, 14'($urandom)};
            sa = 4'($urandom_range(0, 7));
            ready_mode = 2;
            s0 = stab_err;
            model(sa, eh, ee, ep);
            run_prog(sa, 600, done, lat);
            checks++;
            if (!done || halted !== eh || error !== ee || q_diff() !== -1 || tr_diff() !== -1 || stab_err !== s0) begin
                failures++;
                $display("FAIL random_prog%0d: done=%0d halted=%0d/%0d error=%0d/%0d cmds=%0d/%0d diff=%0d trace=%0d stab=%0d",
                         n, done, halted, eh, error, ee, got.size(), exp_q.size(), q_diff(), tr_diff(), stab_err - s0);
            end
            $display("random_prog%0d start=%0d cmds=%0d halted=%0d error=%0d", n, sa, got.size(), halted, error);
        end
    endtask

    task automatic test_async_reset;
        bit seen;
        mem[0] = i_mm(12'd3, 12'd4); mem[1] = i_jmp(14'd1);
        ready_mode = 3;
        @(posedge clk); #1 start = 1'b1; start_addr = 4'd0;
        @(posedge clk); #1 start = 1'b0;
        wait_valid(seen);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || cmd_valid !== 1'b0 || busy !== 1'b0 || pc !== '0) begin
            failures++;
            $display("FAIL async_reset: seen=%0d valid=%0d busy=%0d pc=%0d want 1 0 0 0", seen, cmd_valid, busy, pc);
        end
        @(negedge clk); rst_n = 1'b1;
        ready_mode = 0;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_repeat_accmov;
        test_repeat_zero;
        test_error;
        test_wrap;
        test_abort;
        test_random;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
